// File: rtl/alu_pkg.sv
// Shared constants for the handshaked N-bit ALU: op codes, FSM state encoding
// and flag-vector bit positions.
package alu_pkg;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_SLT  = 3'b001;
  localparam logic [2:0] OP_OR   = 3'b010;
  localparam logic [2:0] OP_XOR  = 3'b011;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_ADDI = 3'b101;
  localparam logic [2:0] OP_MOD  = 3'b110;
  localparam logic [2:0] OP_SLTU = 3'b111;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DIV  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int FLAG_Z    = 0;
  localparam int FLAG_N    = 1;
  localparam int FLAG_C    = 2;
  localparam int FLAG_V    = 3;
  localparam int FLAG_DIV0 = 4;
  localparam int FLAG_W    = 5;

endpackage

// File: rtl/mod_divider_seq.sv
// Iterative restoring remainder unit: one quotient bit per cycle, WIDTH cycles
// after start, then a one-cycle done pulse with rem valid.
module mod_divider_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] rem
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] divisor;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   rem_sh;
  logic             ge;
  logic [WIDTH-1:0] rem_sub;

  // When ge holds the difference is below the divisor, so WIDTH bits suffice.
  assign rem_sh  = {rem, quo[WIDTH-1]};
  assign ge      = (rem_sh >= {1'b0, divisor});
  assign rem_sub = rem_sh[WIDTH-1:0] - divisor;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quo     <= '0;
      divisor <= '0;
      rem     <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start && !busy) begin
        quo     <= a;
        divisor <= b;
        rem     <= '0;
        cnt     <= '0;
        busy    <= 1'b1;
      end else if (busy) begin
        rem <= ge ? rem_sub : rem_sh[WIDTH-1:0];
        quo <= {quo[WIDTH-2:0], ge};
        cnt <= cnt + CW'(1);
        if (cnt == CW'(WIDTH - 1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/alu_seq_nbit.sv
// Handshaked N-bit ALU with status flags and a multi-cycle MOD.
// The remainder op is implemented only when ALU_SEQ_MOD_EN is defined; otherwise op 110 yields 0.
module alu_seq_nbit
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic             bnegate,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v,
  output logic             flag_div0,
  output logic [1:0]       dbg_state
);

  logic [1:0]        state;
  logic [FLAG_W-1:0] flags;
  logic              accept;
  logic [WIDTH-1:0]  mb;
  logic [WIDTH:0]    sum_add;
  logic [WIDTH:0]    sum_addi;
  logic [WIDTH-1:0]  res_c;
  logic              c_c;
  logic              v_c;
  logic              div_busy;

`ifdef ALU_SEQ_MOD_EN
  logic             div_start;
  logic             div_done;
  logic [WIDTH-1:0] div_rem;
`endif

  function automatic logic [FLAG_W-1:0] pack_flags(input logic [WIDTH-1:0] r,
                                                   input logic c, input logic v,
                                                   input logic d0);
    logic [FLAG_W-1:0] f;
    f            = '0;
    f[FLAG_Z]    = (r == '0);
    f[FLAG_N]    = r[WIDTH-1];
    f[FLAG_C]    = c;
    f[FLAG_V]    = v;
    f[FLAG_DIV0] = d0;
    return f;
  endfunction

  // Valid/ready: a transfer happens on a rising edge where valid and ready are
  // both high; the producer holds valid and payload steady until that edge.
  assign in_ready = (state == S_IDLE) && !div_busy && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  assign mb       = bnegate ? ~b : b;
  assign sum_add  = {1'b0, a} + {1'b0, mb} + {{WIDTH{1'b0}}, bnegate};
  assign sum_addi = {1'b0, a} + {1'b0, b};

  always_comb begin
    res_c = '0;
    c_c   = 1'b0;
    v_c   = 1'b0;
    case (op)
      OP_AND:  res_c = a & mb;
      OP_SLT:  res_c = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_OR:   res_c = a | mb;
      OP_XOR:  res_c = a ^ b;
      OP_ADD: begin
        res_c = sum_add[WIDTH-1:0];
        c_c   = sum_add[WIDTH];
        v_c   = (a[WIDTH-1] == mb[WIDTH-1]) && (sum_add[WIDTH-1] != a[WIDTH-1]);
      end
      OP_ADDI: begin
        res_c = sum_addi[WIDTH-1:0];
        c_c   = sum_addi[WIDTH];
        v_c   = (a[WIDTH-1] == b[WIDTH-1]) && (sum_addi[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SLTU: res_c = {{(WIDTH-1){1'b0}}, (a < b)};
      default: res_c = '0;
    endcase
  end

`ifdef ALU_SEQ_MOD_EN
  assign div_start = accept && (op == OP_MOD) && (b != '0);

  mod_divider_seq #(
    .WIDTH (WIDTH)
  ) u_div (
    .clk   (clk),
    .rst_n (rst_n),
    .start (div_start),
    .a     (a),
    .b     (b),
    .busy  (div_busy),
    .done  (div_done),
    .rem   (div_rem)
  );
`else
  assign div_busy = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      flags     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (op == OP_MOD) begin
`ifdef ALU_SEQ_MOD_EN
              if (b == '0) begin
                result    <= a;
                flags     <= pack_flags(a, 1'b0, 1'b0, 1'b1);
                out_valid <= 1'b1;
                state     <= S_DONE;
              end else begin
                out_valid <= 1'b0;
                state     <= S_DIV;
              end
`else
              result    <= '0;
              flags     <= '0;
              out_valid <= 1'b1;
`endif
            end else begin
              result    <= res_c;
              flags     <= pack_flags(res_c, c_c, v_c, 1'b0);
              out_valid <= 1'b1;
            end
          end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
          end
        end
`ifdef ALU_SEQ_MOD_EN
        S_DIV: begin
          if (div_done) begin
            result    <= div_rem;
            flags     <= pack_flags(div_rem, 1'b0, 1'b0, 1'b0);
            out_valid <= 1'b1;
            state     <= S_DONE;
          end
        end
`endif
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign flag_z    = flags[FLAG_Z];
  assign flag_n    = flags[FLAG_N];
  assign flag_c    = flags[FLAG_C];
  assign flag_v    = flags[FLAG_V];
  assign flag_div0 = flags[FLAG_DIV0];
  assign dbg_state = state;

endmodule

// File: tb/tb_alu_seq_nbit.sv
// Directed and randomized bench for alu_seq_nbit; MOD expectations follow
// whether ALU_SEQ_MOD_EN is defined for the build.
`timescale 1ns/1ps
module tb_alu_seq_nbit;
  import alu_pkg::*;

  localparam int W  = 16;
  localparam int EW = W + 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2:0]    op = 3'b000;
  logic          bnegate = 1'b0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  result;
  logic          flag_z, flag_n, flag_c, flag_v, flag_div0;
  logic [1:0]    dbg_state;

  int tests = 0;
  int fails = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] obs;
  logic [4:0]    flg;
  logic [EW-1:0] prev_obs = '0;
  logic          prev_stall = 1'b0;

  assign flg = {flag_div0, flag_v, flag_c, flag_n, flag_z};
  assign obs = {flg, result};

  alu_seq_nbit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .bnegate   (bnegate),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flag_z    (flag_z),
    .flag_n    (flag_n),
    .flag_c    (flag_c),
    .flag_v    (flag_v),
    .flag_div0 (flag_div0),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $error("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // Returns {div0, v, c, n, z, result} from the op definitions using plain integer math.
  function automatic logic [EW-1:0] model(input logic [2:0] o, input logic [W-1:0] x,
                                          input logic [W-1:0] y, input logic bn);
    longint ux, uy, umb, sx, smb, s, cin;
    longint modv;
    logic [W-1:0] r;
    logic c, v, d0;
    modv = longint'(1) << W;
    ux = longint'(x);
    uy = longint'(y);
    umb = bn ? (modv - 1 - uy) : uy;
    sx = longint'($signed(x));
    r = '0; c = 1'b0; v = 1'b0; d0 = 1'b0;
    case (o)
      OP_AND:  r = x & W'(umb);
      OP_SLT:  r = ($signed(x) < $signed(y)) ? W'(1) : W'(0);
      OP_OR:   r = x | W'(umb);
      OP_XOR:  r = x ^ y;
      OP_ADD, OP_ADDI: begin
        if (o == OP_ADDI) begin
          umb = uy;
          cin = 0;
        end else begin
          cin = bn ? 1 : 0;
        end
        s   = ux + umb + cin;
        r   = W'(s % modv);
        c   = (s >= modv);
        smb = (umb >= modv / 2) ? umb - modv : umb;
        s   = sx + smb + cin;
        v   = (s > modv / 2 - 1) || (s < -(modv / 2));
      end
      OP_MOD: begin
`ifdef ALU_SEQ_MOD_EN
        if (uy == 0) begin
          r  = x;
          d0 = 1'b1;
        end else begin
          r = W'(ux % uy);
        end
`else
        return '0;
`endif
      end
      default: r = (ux < uy) ? W'(1) : W'(0);
    endcase
    return {d0, v, c, r[W-1], (r == '0), r};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    tests++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) check("hold_stable", 64'(obs), 64'(prev_obs));
      if (out_valid && out_ready) begin
        tests++;
        assert (exp_q.size() != 0) else begin
          fails++;
          $error("FAIL sb_unexpected: observed %0h expected none", obs);
        end
        if (exp_q.size() != 0) check("sb_result", 64'(obs), 64'(exp_q.pop_front()));
      end
      if (in_valid && in_ready) exp_q.push_back(model(op, a, b, bnegate));
      prev_stall = out_valid && !out_ready;
      prev_obs   = obs;
    end
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+1; returns at posedge+1 after the accept edge.
  task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic bn, input bit rnd_ready);
    int n;
    n = 0;
    op = o; a = x; b = y; bnegate = bn; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 300) begin
      @(posedge clk); #1;
      if (rnd_ready) out_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("issue_wait", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    op = 3'($urandom); a = W'($urandom); b = W'($urandom); bnegate = 1'($urandom);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 6))
      0: return '0;
      1: return '1;
      2: return 16'h7FFF;
      3: return 16'h8000;
      4: return W'($urandom_range(1, 9));
      default: return W'($urandom);
    endcase
  endfunction

  // ---------------- directed + random sequence ----------------
  initial begin
    int cnt;
    bit seen;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_result", 64'(result), 64'd0);
    check("rst_flags", 64'(flg), 64'd0);
    check("rst_state", 64'(dbg_state), 64'(S_IDLE));

    @(posedge clk); #1;
    issue(OP_ADD, 16'h7FFF, 16'h0001, 1'b0, 1'b0);
    @(negedge clk);
    check("add_valid", 64'(out_valid), 64'd1);
    check("add_result", 64'(result), 64'h8000);
    check("add_flags", 64'(flg), 64'b01010);

    @(posedge clk); #1;
    issue(OP_ADD, 16'h0005, 16'h0005, 1'b1, 1'b0);
    @(negedge clk);
    check("sub_result", 64'(result), 64'h0);
    check("sub_flags", 64'(flg), 64'b00101);

    @(posedge clk); #1;
    issue(OP_SLT, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
    @(negedge clk);
    check("slt_result", 64'(result), 64'd1);
    @(posedge clk); #1;
    issue(OP_SLTU, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
    @(negedge clk);
    check("sltu_result", 64'(result), 64'd0);
    check("sltu_flags", 64'(flg), 64'b00001);

`ifdef ALU_SEQ_MOD_EN
    @(posedge clk); #1;
    issue(OP_MOD, 16'd100, 16'd7, 1'b0, 1'b0);
    cnt = 0;
    seen = 1'b0;
    @(negedge clk);
    while (!out_valid && cnt < 40) begin
      if (in_ready) seen = 1'b1;
      cnt++;
      @(negedge clk);
    end
    check("mod_latency", 64'(cnt), 64'd17);
    check("mod_in_ready_low", 64'(seen), 64'd0);
    check("mod_result", 64'(result), 64'd2);
    check("mod_flags", 64'(flg), 64'b00000);

    @(posedge clk); #1;
    issue(OP_MOD, 16'h1234, 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    check("mod0_valid", 64'(out_valid), 64'd1);
    check("mod0_result", 64'(result), 64'h1234);
    check("mod0_flags", 64'(flg), 64'b10000);
`else
    @(posedge clk); #1;
    issue(OP_MOD, 16'd9, 16'd4, 1'b0, 1'b0);
    @(negedge clk);
    check("moddis_valid", 64'(out_valid), 64'd1);
    check("moddis_result", 64'(result), 64'd0);
    check("moddis_flags", 64'(flg), 64'b00000);
`endif

    // Backpressure: result must hold while the consumer stalls.
    @(posedge clk); #1;
    out_ready = 1'b0;
    issue(OP_AND, 16'hF0F0, 16'hFF00, 1'b0, 1'b0);
    op = OP_XOR; a = 16'h1234; b = 16'h00FF; bnegate = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_result", 64'(result), 64'hF000);
      check("bp_in_ready", 64'(in_ready), 64'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_accept_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("bp_next_valid", 64'(out_valid), 64'd1);
    check("bp_next_result", 64'(result), 64'h12CB);

    // Reset in the middle of a long MOD.
    @(posedge clk); #1;
    issue(OP_MOD, 16'hFFFF, 16'd3, 1'b0, 1'b0);
    repeat (7) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("midrst_valid", 64'(out_valid), 64'd0);
    check("midrst_result", 64'(result), 64'd0);
    check("midrst_flags", 64'(flg), 64'd0);
    check("midrst_state", 64'(dbg_state), 64'(S_IDLE));
    @(posedge clk); #1 rst_n = 1'b1;
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("midrst_no_result", 64'(seen), 64'd0);
    @(posedge clk); #1;
    issue(OP_XOR, 16'hAAAA, 16'hFFFF, 1'b0, 1'b0);
    @(negedge clk);
    check("xor_after_rst", 64'(result), 64'h5555);

    // Randomized traffic with random consumer stalls.
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      out_ready = ($urandom_range(0, 2) != 0);
      issue(3'($urandom_range(0, 7)), pick(), pick(), 1'($urandom), 1'b1);
      repeat ($urandom_range(0, 2)) begin
        out_ready = ($urandom_range(0, 2) != 0);
        @(posedge clk); #1;
      end
    end
    out_ready = 1'b1;
    cnt = 0;
    while (exp_q.size() != 0 && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_seq_nbit.md
# alu_seq_nbit

Parametrised, handshaked N-bit ALU that succeeds the bit-slice ALU in the 16-bit CPU datapath. It keeps the same 3-bit operation encoding and B-negate control, adds status flags, and executes MOD as a true multi-cycle restoring-division operation. It sits between the register-file read stage and writeback, behind a valid/ready handshake on both sides.

## Interface
- `WIDTH`, 16: operand and result width, ≥4.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: operation request.
- `in_ready` out 1: ALU can accept a request.
- `op` in 3: operation code, listed under Operation.
- `bnegate` in 1: invert B and force carry-in to 1 (two's-complement subtract) for AND, OR and ADD.
- `a`, `b` in WIDTH: operands; `b` carries the immediate for ADDI.
- `out_valid` out 1: result available.
- `out_ready` in 1: consumer accepts the result.
- `result` out WIDTH: registered result.
- `flag_z`, `flag_n`, `flag_c`, `flag_v` out 1 each: zero, negative (MSB), carry-out, and signed overflow.
- `flag_div0` out 1: MOD with `b == 0`.

## Operation
- Op codes:
  - 000 AND: `a & mb`.
  - 001 SLT: signed `a < b`, giving 1 or 0.
  - 010 OR: `a | mb`.
  - 011 XOR: `a ^ b`.
  - 100 ADD/SUB: `a + mb + bnegate`.
  - 101 ADDI: `a + b` with `bnegate` ignored.
  - 110 MOD: unsigned `a % b`.
  - 111 SLTU: unsigned `a < b`.
  - Here `mb = bnegate ? ~b : b`.
- Flag rules:
  - `flag_c` and `flag_v` are valid only for ops 100 and 101; they are 0 for every other op.
  - `flag_v` = (operand signs equal) && (result sign differs), using `mb` as the second operand.
  - `flag_z` and `flag_n` are derived from `result` for every op.
- Arithmetic is modulo 2^WIDTH; carry-out is bit WIDTH of the (WIDTH+1)-bit sum.
- State machine:
  - IDLE: on `in_valid && in_ready`, ops other than 110 compute combinationally and load the output register, then go to IDLE with `out_valid=1`. Op 110 latches operands, clears the remainder and the iteration counter, and goes to DIV.
  - DIV: one restoring step per cycle. Shift `{rem, quotient}` left by 1, then subtract `b` if `rem >= b`. After WIDTH steps, load `result = rem` and go to DONE.
  - DONE: `out_valid=1`; on `out_ready`, go to IDLE.
- `in_ready` = (state == IDLE) && (!out_valid || out_ready). A new single-cycle op may be accepted in the same cycle the previous result drains (back-to-back throughput of 1 per cycle).
- MOD by zero: skip DIV and go directly to DONE next cycle with `result = a`, `flag_div0 = 1`, and all other flags computed from `result`.
- `result` and the flags hold stable while `out_valid && !out_ready`.
- Inputs are sampled only on the accept cycle; changes afterwards have no effect.

## Timing
- Reset (async assert, sync deassert by the system): state IDLE; `out_valid=0`, `in_ready=1` from the first cycle after release; `result=0`; all flags 0; counter 0.
- Single-cycle ops: accept on edge k; `out_valid`, `result` and flags are visible after edge k (latency 1).
- MOD (`b != 0`): accept on edge k; `out_valid` is visible after edge k+WIDTH+1 (WIDTH iterations plus the load into DONE). `in_ready=0` throughout.
- MOD (`b == 0`): latency 1.
- Reset mid-DIV aborts with no result: `out_valid` stays 0 and the state returns to IDLE.
- `out_ready` asserted without `out_valid` is ignored.

## Configuration
- `ALU_SEQ_MOD_EN` defined: MOD is implemented as above.
- `ALU_SEQ_MOD_EN` undefined:
  - The divider is not instantiated and the DIV state is absent.
  - Op 110 completes in 1 cycle with `result=0`, all flags 0, and `flag_div0=0`.

## Structure
- Shared package `alu_pkg`:
  - Op-code localparams (`OP_AND` … `OP_SLTU`).
  - State encoding (`S_IDLE`, `S_DIV`, `S_DONE`).
  - Flag-vector index constants.
- Sub-module `mod_divider_seq #(WIDTH)`:
  - Iterative remainder unit with `start`, `a`, `b`, `busy`, `done`, `rem`.
  - Instantiated only under `ALU_SEQ_MOD_EN`.
- The top level holds the FSM, the single-cycle datapath, the output register and the handshake logic.

## Test plan
All scenarios use WIDTH=16.
- ADD/SUB:
  - op=100, a=0x7FFF, b=0x0001, bnegate=0 → result 0x8000, v=1, n=1, c=0, one cycle after accept.
  - Then bnegate=1, a=0x0005, b=0x0005 → result 0, z=1, c=1.
- Compares: op=001, a=0xFFFF, b=0x0001 → result 1; op=111 with the same operands → result 0.
- MOD:
  - op=110, a=100, b=7 → `in_ready` low for 17 cycles, then result 2, `flag_div0=0`.
  - b=0, a=0x1234 → result 0x1234 and `flag_div0=1` after 1 cycle.
- Backpressure: `out_ready` held low for 5 cycles after an AND (a=0xF0F0, b=0xFF00 → 0xF000). Result stays stable, `in_ready=0` throughout; the next op is accepted on the cycle `out_ready` rises.
- Reset: deassert `rst_n` on cycle 8 of MOD (a=0xFFFF, b=3) → outputs 0, `out_valid` never asserts, and a fresh XOR (0xAAAA ^ 0xFFFF) yields 0x5555.
- Build with `ALU_SEQ_MOD_EN` undefined: op=110, a=9, b=4 → result 0 after 1 cycle, all flags 0.
